fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO: fetch one word, send it LSB-first
// with optional even parity, then look at the FIFO again.
module fifo_uart_tx #(
  parameter int DATA_WITH    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_WITH-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  // state  | meaning
  // IDLE   | line high, issue a read when the FIFO has data
  // WAIT   | FIFO output valid, capture word and parity
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | even-parity bit
  // STOP   | stop bit (1)
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WITH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WITH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WITH-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bit_end;

  assign bit_end    = (baud_cnt_q == BAUD_LAST);
  assign fifo_rd_en = (state_q == S_IDLE) && !fifo_empty && !rst;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_rd_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d    = fifo_dout;
        parity_d   = ^fifo_dout;
        baud_cnt_d = '0;
        state_d    = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shreg_d    = shreg_q >> 1;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops track the state in the same cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (with and without parity) fed by FIFO models,
// checked every cycle against a frame-timeline model plus a few literal frame patterns.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [2][1024];
  int wr_ptr [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};
  int mrd    [2] = '{0, 0};
  int par    [2] = '{1, 0};

  logic empty0, empty1, rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;
  logic [7:0] dout0 = 8'h00;
  logic [7:0] dout1 = 8'h00;
  assign empty0 = (rd_ptr[0] == wr_ptr[0]);
  assign empty1 = (rd_ptr[1] == wr_ptr[1]);

  fifo_uart_tx #(.DATA_WITH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  fifo_uart_tx #(.DATA_WITH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  // FIFO output is only meaningful the cycle after a read; scramble it otherwise.
  always @(posedge clk) begin
    if (rd0 && !empty0) begin
      dout0     <= mem[0][rd_ptr[0]];
      rd_ptr[0] <= rd_ptr[0] + 1;
    end else dout0 <= 8'($urandom);
    if (rd1 && !empty1) begin
      dout1     <= mem[1][rd_ptr[1]];
      rd_ptr[1] <= rd_ptr[1] + 1;
    end else dout1 <= 8'($urandom);
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle-time %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic slot_bit(logic [7:0] w, int p, int s);
    if (s == 0) return 1'b0;
    if (s <= DW) return w[s-1];
    if (p != 0 && s == DW + 1) return ^w;
    return 1'b1;
  endfunction

  // Model: a frame fetched at cycle b occupies cycles b+1 .. b+flen+1, frame_done at b+flen+2.
  int         cyc = 0;
  int         base [2] = '{0, 0};
  bit         active [2] = '{0, 0};
  logic [7:0] word [2];
  int         rd_cnt [2] = '{0, 0};
  int         fd_cnt [2] = '{0, 0};
  int         busy_cnt = 0;
  int         last_rd [2] = '{0, 0};
  int         last_gap [2] = '{0, 0};
  int         gaps1 [$];
  int         o, flen;
  logic       e_tx, e_busy, e_fd, e_rd, a_tx, a_busy, a_fd, a_rd;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      flen = (2 + DW + par[k]) * CPB;
      o    = cyc - base[k];
      if (rst) begin
        e_tx = 1'b1; e_busy = 1'b0; e_fd = 1'b0; e_rd = 1'b0;
        active[k] = 1'b0;
      end else if (active[k] && o >= 1 && o <= flen + 1) begin
        e_busy = 1'b1; e_fd = 1'b0; e_rd = 1'b0;
        e_tx = (o == 1) ? 1'b1 : slot_bit(word[k], par[k], (o - 2) / CPB);
      end else begin
        e_tx = 1'b1; e_busy = 1'b0;
        e_fd = active[k] && (o == flen + 2);
        e_rd = (mrd[k] != wr_ptr[k]);
        active[k] = 1'b0;
        if (e_rd) begin
          base[k]   = cyc;
          word[k]   = mem[k][mrd[k]];
          mrd[k]    = mrd[k] + 1;
          active[k] = 1'b1;
        end
      end
      a_tx   = (k == 0) ? tx0 : tx1;
      a_busy = (k == 0) ? busy0 : busy1;
      a_fd   = (k == 0) ? fd0 : fd1;
      a_rd   = (k == 0) ? rd0 : rd1;
      chk($sformatf("tx[%0d]", k), a_tx, e_tx);
      chk($sformatf("busy[%0d]", k), a_busy, e_busy);
      chk($sformatf("frame_done[%0d]", k), a_fd, e_fd);
      chk($sformatf("rd_en[%0d]", k), a_rd, e_rd);
      if (a_busy === 1'b1) busy_cnt++;
      if (a_fd === 1'b1) fd_cnt[k]++;
      if (a_rd === 1'b1) begin
        rd_cnt[k]++;
        if (last_rd[k] > 0) begin
          last_gap[k] = cyc - last_rd[k];
          if (k == 1) gaps1.push_back(last_gap[k]);
        end
        last_rd[k] = cyc;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] v);
    mem[k][wr_ptr[k]] = v;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  function automatic logic model_idle(int k);
    return (mrd[k] == wr_ptr[k]) &&
           (!active[k] || (cyc - base[k]) > (2 + DW + par[k]) * CPB + 1);
  endfunction

  task automatic wait_drain(input int lim);
    int   n = 0;
    logic done = 1'b0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
      done = model_idle(0) && model_idle(1) && !busy0 && !busy1;
    end
    repeat (3) @(negedge clk);
    chk("drain_done", done, 1);
  endtask

  task automatic wait_rd0(input string name);
    int n = 0;
    @(negedge clk);
    while (rd0 !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, rd0, 1);
  endtask

  // Samples the first cycle of each of the 11 bit slots of an instance-0 frame.
  task automatic grab(input string name, output logic [10:0] bits);
    bits = '1;
    wait_rd0(name);
    @(negedge clk);
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      bits[b] = tx0;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  logic [10:0] fr;
  int          fd_before;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    repeat (100) @(posedge clk);
    chk("idle_rd", rd_cnt[0] + rd_cnt[1], 0);
    chk("idle_fd", fd_cnt[0] + fd_cnt[1], 0);
    chk("idle_busy", busy_cnt, 0);

    @(posedge clk); #1 push(0, 8'hA5);
    grab("rd_a5", fr);
    chk("frame_a5", fr, 11'b10101001010);
    wait_drain(200);

    @(posedge clk); #1 push(0, 8'h07);
    grab("rd_07", fr);
    chk("frame_07", fr, 11'b11000001110);
    wait_drain(200);
    chk("rd_cnt_two", rd_cnt[0], 2);
    chk("fd_cnt_two", fd_cnt[0], 2);

    @(posedge clk); #1 push(1, 8'h01); push(1, 8'h80); push(1, 8'hFF);
    wait_drain(400);
    chk("np_rd_cnt", rd_cnt[1], 3);
    chk("np_fd_cnt", fd_cnt[1], 3);
    chk("np_gap_count", gaps1.size(), 2);
    if (gaps1.size() == 2) begin
      chk("np_gap0", gaps1[0], 42);
      chk("np_gap1", gaps1[1], 42);
    end

    @(posedge clk); #1 push(0, 8'h3C);
    fd_before = fd_cnt[0];
    wait_rd0("rd_3c");
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_fd", fd0, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1 push(0, 8'h5A);
    grab("rd_5a", fr);
    chk("frame_5a", fr, 11'b10010110100);
    wait_drain(200);
    chk("rst_rd_cnt", rd_cnt[0], 4);
    chk("rst_fd_cnt", fd_cnt[0], fd_before + 1);

    @(posedge clk); #1 push(0, 8'hC3);
    wait_rd0("rd_c3");
    repeat (43) @(posedge clk);
    #1 push(0, 8'h96);
    wait_drain(200);
    chk("stop_push_gap", last_gap[0], 46);
    chk("stop_push_rd_cnt", rd_cnt[0], 6);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) < 3) push(0, 8'($urandom));
      if ($urandom_range(0, 99) < 2) push(1, 8'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end
    wait_drain(6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
